bus_rr_arbiter: RTL and testbench
=================================

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter DATA_W, default 4, giving the shared data bus width.
REQ-003 The block SHALL have parameter MAX_BURST, default 8, giving the maximum number of beats per grant (1..255).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  NUM_REQ  per-requester request; also marks that requester's beat as valid while it is granted.
REQ-007 req_data  input  NUM_REQ*DATA_W  per-requester data; slice i is bits [i*DATA_W +: DATA_W].
REQ-008 req_last  input  NUM_REQ  per-requester end-of-burst flag, qualified by that requester's beat.
REQ-009 ready  input  1  downstream consumer accepts the current beat.
REQ-010 grant  output  NUM_REQ  one-hot grant, registered.
REQ-011 data_bus  output  DATA_W  shared data bus.
REQ-012 valid  output  1  data_bus carries a beat.
REQ-013 busy  output  1  a burst is in progress.
REQ-014 owner  output  $clog2(NUM_REQ)  index of the granted requester; 0 when idle.

Function
REQ-015 The FSM SHALL have two states: IDLE and BUSY.
REQ-016 In IDLE with req != 0, the block SHALL select the first asserted requester at or after rr_ptr, scanning upward and wrapping at NUM_REQ.
REQ-017 On that selection it SHALL register grant and owner and enter BUSY on the next edge (1-cycle latency from req to grant).
REQ-018 In IDLE, grant SHALL be 0, valid 0, busy 0, and data_bus 0.
REQ-019 In BUSY, valid SHALL equal req[owner] (combinational), and data_bus SHALL equal slice owner of req_data when valid=1 and 0 otherwise.
REQ-020 A beat SHALL transfer on a cycle with valid=1 and ready=1; beat_cnt SHALL be cleared on grant and SHALL increment by 1 per transfer.
REQ-021 A burst SHALL end on the first of three events: (a) transfer with req_last[owner]=1; (b) transfer that makes beat_cnt equal MAX_BURST; (c) req[owner]=0 while BUSY (withdrawal, no transfer).
REQ-022 On burst end the block SHALL return to IDLE, clear grant and owner on the next edge, and set rr_ptr to (owner+1) mod NUM_REQ.
REQ-023 The block SHALL insert one idle cycle between consecutive grants, so no requester can receive a grant in the cycle a burst ends.
REQ-024 When valid=1 and ready=0, the block SHALL hold grant, hold beat_cnt and end no burst, except by withdrawal.
REQ-025 Requests from non-owners in BUSY SHALL be ignored and SHALL NOT change grant.
REQ-026 Events (a) and (b) on the same transfer SHALL be treated as a single burst end.
REQ-027 With MAX_BURST=1, every grant SHALL be exactly one beat.
REQ-028 beat_cnt SHALL be $clog2(MAX_BURST+1) bits wide and SHALL never wrap.

Reset
REQ-029 rst=1 at a clock edge SHALL force state IDLE, grant 0, owner 0, rr_ptr 0 and beat_cnt 0, regardless of state.
REQ-030 While rst=1, valid, busy and data_bus SHALL read 0.
REQ-031 A reset mid-burst SHALL abort the burst; no beat is counted in the reset cycle, and arbitration restarts from requester 0 on the first cycle after rst deasserts.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (IDLE, BUSY) and the default parameter constants.
REQ-033 The rotating-priority search SHALL be implemented as one combinational sub-module, rr_pick (inputs req, rr_ptr; outputs found, idx).

Verification
REQ-034 The bench SHALL cover a single request: after reset, req=4'b0100 with req_data slice2=4'hA and ready=1 -> grant=4'b0100 and owner=2 one cycle later; data_bus=4'hA with valid=1; req_last on the 3rd beat -> grant=0 on the next cycle, rr_ptr=3.
REQ-035 The bench SHALL cover round-robin order: req=4'b1111 held, every requester asserting req_last on its first beat -> grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
REQ-036 The bench SHALL cover the burst cap: MAX_BURST=8, req=4'b0001, req_last never asserted, ready=1 -> exactly 8 beats, then grant=0; a re-grant to requester 0 follows after one idle cycle.
REQ-037 The bench SHALL cover backpressure: while owner=1, ready=0 for 5 cycles with req_last=1 -> grant held, data_bus stable, burst ends only on the cycle ready returns to 1.
REQ-038 The bench SHALL cover withdrawal: owner=3, req[3] dropped after 2 beats -> valid=0 immediately, grant=0 on the next edge, rr_ptr=0.
REQ-039 The bench SHALL cover reset mid-burst: rst=1 during beat 4 of owner 2 -> grant=0, valid=0 on the next edge; after release, req=4'b1100 -> grant=4'b0100.

Source files
------------

// File: rtl/bus_rr_arbiter_pkg.sv
// Shared types and default constants for the round-robin bus arbiter.
package bus_rr_arbiter_pkg;

  // Arbiter control states: waiting for a request, or serving one owner's burst.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 4;
  localparam int DEF_MAX_BURST = 8;

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Rotating-priority search: finds the first asserted request at or after
// rr_ptr, scanning upward and wrapping at NUM_REQ. Purely combinational.
module rr_pick
  import bus_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  // cand_idx[k] is the requester sitting k places after rr_ptr (wrapped).
  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] hit;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [IDX_W:0] sum;
    assign sum = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
    // rr_ptr is always < NUM_REQ, so one conditional subtraction wraps it.
    assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ))
                          ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                          : IDX_W'(sum);
    assign hit[gi] = req[cand_idx[gi]];
  end

  // Smallest distance from rr_ptr wins: scan from far to near so near overrides.
  always_comb begin
    found = |hit;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (hit[k]) idx = cand_idx[k];
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for a shared data bus. One owner at a time holds the
// bus for a burst; bursts end on last flag, beat cap or withdrawal, and an
// idle cycle always separates consecutive grants.
module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic                       ready,
  output logic [NUM_REQ-1:0]         grant,
  output logic [DATA_W-1:0]          data_bus,
  output logic                       valid,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_CAP = CNT_W'(MAX_BURST);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  arb_state_t         state_reg, state_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0]   owner_reg, owner_next;
  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;

  logic [DATA_W-1:0]  req_slice [NUM_REQ];
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               in_busy;
  logic               owner_req;
  logic               owner_last;
  logic               transfer;
  logic               burst_done;
  logic               withdraw;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign req_slice[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_reg),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  assign in_busy    = (state_reg == BUSY);
  assign owner_req  = req[owner_reg];
  assign owner_last = req_last[owner_reg];

  // Outputs read as idle while reset is held, even before the reset edge lands.
  assign busy     = in_busy && !rst;
  assign valid    = busy && owner_req;
  assign data_bus = valid ? req_slice[owner_reg] : '0;
  assign grant    = grant_reg;
  assign owner    = owner_reg;

  // A transfer that hits either the last flag or the cap ends the burst once.
  assign transfer   = valid && ready;
  assign burst_done = transfer && (owner_last || (beat_cnt_reg + CNT_W'(1) == BURST_CAP));
  assign withdraw   = in_busy && !owner_req;

  // State register with synchronous reset back to a clean idle arbiter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      owner_reg    <= '0;
      rr_ptr_reg   <= '0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      owner_reg    <= owner_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  // Next-state: grant from IDLE, count beats and detect burst end in BUSY.
  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    owner_next    = owner_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next    = BUSY;
          grant_next    = NUM_REQ'(1) << pick_idx;
          owner_next    = pick_idx;
          beat_cnt_next = '0;
        end
      end
      BUSY: begin
        if (withdraw || burst_done) begin
          // Returning through IDLE guarantees the idle cycle between grants.
          state_next    = IDLE;
          grant_next    = '0;
          owner_next    = '0;
          beat_cnt_next = '0;
          rr_ptr_next   = (owner_reg == LAST_IDX) ? '0 : owner_reg + IDX_W'(1);
        end else if (transfer) begin
          beat_cnt_next = beat_cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: directed scenarios plus a long
// randomized run compared against a behavioural model of the arbitration rules.
module tb_bus_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int MB = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic            ready;
  logic [N-1:0]    grant;
  logic [DW-1:0]   data_bus;
  logic            valid;
  logic            busy;
  logic [1:0]      owner;

  int checks   = 0;
  int failures = 0;

  // Model: owner of the bus (-1 when idle), rotating pointer, beats moved.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_beats = 0;

  always #5 clk = ~clk;

  bus_rr_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .req_last (req_last),
    .ready    (ready),
    .grant    (grant),
    .data_bus (data_bus),
    .valid    (valid),
    .busy     (busy),
    .owner    (owner)
  );

  // Apply the arbitration rules to the inputs present at the coming edge.
  task automatic model_step();
    bit ended;
    bit picked;
    int cand;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_beats = 0;
    end else if (m_owner < 0) begin
      picked = 0;
      for (int k = 0; k < N; k++) begin
        cand = (m_ptr + k) % N;
        if (!picked && req[cand]) begin
          picked  = 1;
          m_owner = cand;
          m_beats = 0;
        end
      end
    end else begin
      ended = 0;
      if (!req[m_owner]) begin
        ended = 1;
      end else if (ready) begin
        m_beats++;
        if (req_last[m_owner] || m_beats == MB) ended = 1;
      end
      if (ended) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req      = '0;
    req_last = '0;
    ready    = 1'b0;
    tick();
    rst      = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    req      = N'($urandom);
    req_data = (N*DW)'($urandom);
    ready    = 1'b1;
    tick();
    tick();
    if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (data_bus !== 4'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", data_bus); end
    checks++;
    if (owner !== 2'd0) begin failures++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    checks++;
    rst = 1'b0;
    req = '0;
    #1;
  endtask

  task automatic test_single();
    do_reset();
    req      = 4'b0100;
    req_data = 16'h0A00;
    req_last = '0;
    ready    = 1'b1;
    #1;
    if (grant !== 4'b0000) begin failures++; $display("FAIL single_latency got=%b exp=0000", grant); end
    checks++;
    tick();
    if (grant !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b exp=0100", grant); end
    checks++;
    if (owner !== 2'd2) begin failures++; $display("FAIL single_owner got=%0d exp=2", owner); end
    checks++;
    if (valid !== 1'b1 || data_bus !== 4'hA) begin
      failures++; $display("FAIL single_beat got valid=%b data=%h exp valid=1 data=a", valid, data_bus);
    end
    checks++;
    tick();
    tick();
    req_last = 4'b0100;
    #1;
    if (grant !== 4'b0100) begin failures++; $display("FAIL single_hold got=%b exp=0100", grant); end
    checks++;
    tick();
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      failures++; $display("FAIL single_end got grant=%b busy=%b exp grant=0000 busy=0", grant, busy);
    end
    checks++;
    req      = 4'b1111;
    req_last = '0;
    tick();
    if (grant !== 4'b1000) begin failures++; $display("FAIL single_next_ptr got=%b exp=1000", grant); end
    checks++;
    req = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] seq [9];
    seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
            4'b0000, 4'b1000, 4'b0000, 4'b0001};
    do_reset();
    req      = 4'b1111;
    req_last = 4'b1111;
    req_data = (N*DW)'($urandom);
    ready    = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (grant !== seq[i]) begin failures++; $display("FAIL rr_seq step=%0d got=%b exp=%b", i, grant, seq[i]); end
      checks++;
    end
    req      = '0;
    req_last = '0;
    tick();
  endtask

  task automatic test_burst_cap();
    int beats;
    int cycles;
    do_reset();
    req      = 4'b0001;
    req_last = '0;
    req_data = (N*DW)'($urandom);
    ready    = 1'b1;
    tick();
    if (grant !== 4'b0001) begin failures++; $display("FAIL cap_grant got=%b exp=0001", grant); end
    checks++;
    beats  = 0;
    cycles = 0;
    while (grant === 4'b0001 && cycles < 20) begin
      if (valid && ready) beats++;
      tick();
      cycles++;
    end
    if (beats != MB) begin failures++; $display("FAIL cap_beats got=%0d exp=%0d", beats, MB); end
    checks++;
    if (grant !== 4'b0000) begin failures++; $display("FAIL cap_end got=%b exp=0000", grant); end
    checks++;
    tick();
    if (grant !== 4'b0001) begin failures++; $display("FAIL cap_regrant got=%b exp=0001", grant); end
    checks++;
    req = '0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    do_reset();
    req      = 4'b0010;
    req_data = (N*DW)'($urandom);
    held     = req_data[7:4];
    req_last = '0;
    ready    = 1'b1;
    tick();
    ready    = 1'b0;
    req_last = 4'b0010;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (grant !== 4'b0010 || valid !== 1'b1 || data_bus !== held) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got grant=%b valid=%b data=%h exp grant=0010 valid=1 data=%h",
                 i, grant, valid, data_bus, held);
      end
      checks++;
      tick();
    end
    if (grant !== 4'b0010) begin failures++; $display("FAIL bp_after_stall got=%b exp=0010", grant); end
    checks++;
    ready = 1'b1;
    tick();
    if (grant !== 4'b0000) begin failures++; $display("FAIL bp_release got=%b exp=0000", grant); end
    checks++;
    req      = '0;
    req_last = '0;
    tick();
  endtask

  task automatic test_withdraw();
    do_reset();
    req      = 4'b1000;
    req_last = '0;
    req_data = (N*DW)'($urandom);
    ready    = 1'b1;
    tick();
    tick();
    tick();
    req = '0;
    #1;
    if (valid !== 1'b0 || grant !== 4'b1000) begin
      failures++; $display("FAIL wd_immediate got valid=%b grant=%b exp valid=0 grant=1000", valid, grant);
    end
    checks++;
    tick();
    if (grant !== 4'b0000) begin failures++; $display("FAIL wd_end got=%b exp=0000", grant); end
    checks++;
    req = 4'b1111;
    tick();
    if (grant !== 4'b0001) begin failures++; $display("FAIL wd_next_ptr got=%b exp=0001", grant); end
    checks++;
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req      = 4'b0100;
    req_last = '0;
    req_data = (N*DW)'($urandom);
    ready    = 1'b1;
    tick();
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    if (valid !== 1'b0 || busy !== 1'b0 || data_bus !== 4'h0) begin
      failures++; $display("FAIL rstmid_outputs got valid=%b busy=%b data=%h exp 0/0/0", valid, busy, data_bus);
    end
    checks++;
    tick();
    rst = 1'b0;
    req = 4'b1100;
    #1;
    if (grant !== 4'b0000 || valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_abort got grant=%b valid=%b exp grant=0000 valid=0", grant, valid);
    end
    checks++;
    tick();
    if (grant !== 4'b0100) begin failures++; $display("FAIL rstmid_restart got=%b exp=0100", grant); end
    checks++;
    req = '0;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0]  exp_grant;
    logic          exp_busy;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    int            exp_owner;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int b = 0; b < N; b++) begin
        req[b]      = ($urandom_range(0, 9) < 7);
        req_last[b] = ($urandom_range(0, 5) == 0);
      end
      req_data = (N*DW)'($urandom);
      ready    = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 99) == 0);
      #1;
      exp_grant = (m_owner < 0) ? '0 : N'(1) << m_owner;
      exp_owner = (m_owner < 0) ? 0 : m_owner;
      exp_busy  = (m_owner >= 0) && !rst;
      exp_valid = exp_busy && req[exp_owner];
      exp_data  = exp_valid ? req_data[exp_owner*DW +: DW] : '0;
      if (grant !== exp_grant) begin failures++; $display("FAIL rand_grant cyc=%0d got=%b exp=%b", cyc, grant, exp_grant); end
      checks++;
      if (owner !== 2'(exp_owner)) begin failures++; $display("FAIL rand_owner cyc=%0d got=%0d exp=%0d", cyc, owner, exp_owner); end
      checks++;
      if (busy !== exp_busy) begin failures++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
      checks++;
      if (valid !== exp_valid) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, valid, exp_valid); end
      checks++;
      if (data_bus !== exp_data) begin failures++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, data_bus, exp_data); end
      checks++;
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    req_last = '0;
    ready    = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_burst_cap();
    test_backpressure();
    test_withdraw();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
